// File: rtl/imem_encoder.sv
// imem_encoder: packs decoded R-I CPU instruction fields into 32-bit MIPS
// words and writes them sequentially into instruction memory.
// Optional feature macro: ENC_CHECKSUM_EN adds a running-XOR checksum port.
module imem_encoder #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [2:0]        alu_op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              full,
  output logic              err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     cnt_inc;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic                enc_legal;
  logic [31:0]         enc_word;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  // Encode the incoming field bundle into a MIPS word and flag illegal bundles.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a value held (a latch).
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    unique case (fmt)
      2'd0: begin
        enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b000000};
        unique case (alu_op)
          3'b100:  enc_word[5:0] = 6'b100000; // add
          3'b101:  enc_word[5:0] = 6'b100010; // sub
          3'b000:  enc_word[5:0] = 6'b100100; // and
          3'b001:  enc_word[5:0] = 6'b100101; // or
          3'b010:  enc_word[5:0] = 6'b100110; // xor
          3'b011:  enc_word[5:0] = 6'b100111; // nor
          3'b110:  enc_word[5:0] = 6'b101011; // sltu
          default: enc_word[5:0] = 6'b000100; // sllv
        endcase
      end
      2'd1: begin
        enc_word = {6'b000000, rs, rt, imm};
        unique case (alu_op)
          3'b100:  enc_word[31:26] = 6'b001000; // addi
          3'b000:  enc_word[31:26] = 6'b001100; // andi
          3'b010:  enc_word[31:26] = 6'b001110; // xori
          3'b110:  enc_word[31:26] = 6'b001011; // sltiu
          default: enc_legal = 1'b0;            // no immediate form
        endcase
      end
      2'd2:    enc_word = {6'b100011, rs, rt, imm}; // lw
      default: enc_word = {6'b101011, rs, rt, imm}; // sw
    endcase
  end

  // Ready only in IDLE, never once full, and never while clear is asserted.
  assign in_ready = (state_q == IDLE) && !full_q && !clear;
  assign cnt_inc  = cnt_q + (ADDR_W+1)'(1);

  // Next-state logic: clear overrides everything, then accept or retire a write.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
`ifdef ENC_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
`ifdef ENC_CHECKSUM_EN
      csum_d  = 32'h0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (enc_legal) begin
              state_d = WRITE;
              we_d    = 1'b1;
              wdata_d = enc_word;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: begin
          // End of the single WRITE cycle: retire the word.
          state_d = IDLE;
          // Saturate rather than wrap when DEPTH equals the full address space.
          addr_d  = (&addr_q) ? addr_q : addr_q + ADDR_W'(1);
          cnt_d   = cnt_inc;
          full_d  = (cnt_inc == DEPTH_C);
`ifdef ENC_CHECKSUM_EN
          csum_d  = csum_q ^ wdata_q;
`endif
        end
      endcase
    end
  end

  // State and registered outputs; async reset also aborts an in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      addr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      csum_q  <= 32'h0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
`ifdef ENC_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_wdata = wdata_q;
  assign imem_addr  = addr_q;
  assign word_cnt   = cnt_q;
  assign full       = full_q;
  assign err        = err_q;
`ifdef ENC_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_imem_encoder.sv
// Self-checking bench for imem_encoder: directed vector table, hand-written
// corner-case sequences, and randomized traffic against a transaction model.
module tb_imem_encoder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [2:0]        alu_op;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              full;
  logic              err;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  imem_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .alu_op     (alu_op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_cnt   (word_cnt),
    .full       (full),
    .err        (err)
`ifdef ENC_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mnemonic tables indexed by alu_op: R-type func codes and I-type opcodes
  // (6'h00 marks "no immediate form").
  localparam logic [5:0] R_FUNC [8] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                        6'b100000, 6'b100010, 6'b101011, 6'b000100};
  localparam logic [5:0] I_OP   [8] = '{6'b001100, 6'b000000, 6'b001110, 6'b000000,
                                        6'b001000, 6'b000000, 6'b001011, 6'b000000};

  // Returns {legal, word}.
  function automatic logic [32:0] ref_encode(input logic [1:0] f, input logic [2:0] op,
                                             input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [15:0] i);
    logic [5:0] iop;
    iop = I_OP[op];
    case (f)
      2'd0:    return {1'b1, 6'd0, s, t, d, 5'd0, R_FUNC[op]};
      2'd1:    return {(iop != 6'd0), iop, s, t, i};
      2'd2:    return {1'b1, 6'd35, s, t, i};
      default: return {1'b1, 6'd43, s, t, i};
    endcase
  endfunction

  // Transaction-level model: a pending word, words written, sticky error, checksum.
  logic        m_pend;
  logic [31:0] m_wdata;
  int          m_cnt;
  logic        m_err;
  logic [31:0] m_csum;

  task automatic model_reset();
    m_pend = 1'b0; m_wdata = 32'h0; m_cnt = 0; m_err = 1'b0; m_csum = 32'h0;
  endtask

  // One clock: check ready, advance the model across the edge, check outputs.
  task automatic cycle();
    logic        exp_rdy;
    logic [32:0] enc;
    int          exp_addr;
    #1;
    exp_rdy = !m_pend && (m_cnt < DEPTH) && !clear;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    enc = ref_encode(fmt, alu_op, rs, rt, rd, imm);
    @(posedge clk);
    if (clear) begin
      m_pend = 1'b0; m_cnt = 0; m_err = 1'b0; m_csum = 32'h0;
    end else if (m_pend) begin
      m_pend = 1'b0; m_cnt++; m_csum ^= m_wdata;
    end else if (in_valid && exp_rdy) begin
      if (enc[32]) begin m_pend = 1'b1; m_wdata = enc[31:0]; end
      else m_err = 1'b1;
    end
    #1;
    exp_addr = (m_cnt > (1 << ADDR_W) - 1) ? (1 << ADDR_W) - 1 : m_cnt;
    check("imem_we",    32'(imem_we),    32'(m_pend));
    check("imem_wdata", imem_wdata,      m_wdata);
    check("imem_addr",  32'(imem_addr),  32'(exp_addr));
    check("word_cnt",   32'(word_cnt),   32'(m_cnt));
    check("full",       32'(full),       32'(m_cnt == DEPTH));
    check("err",        32'(err),        32'(m_err));
`ifdef ENC_CHECKSUM_EN
    check("checksum",   checksum,        m_csum);
`endif
  endtask

  task automatic drive(input logic [1:0] f, input logic [2:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [15:0] i);
    fmt = f; alu_op = op; rs = s; rt = t; rd = d; imm = i;
  endtask

  task automatic scramble();
    drive(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  typedef struct {
    logic [1:0]  f;
    logic [2:0]  op;
    logic [4:0]  s, t, d;
    logic [15:0] i;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vt [8];
  int   writes;

  initial begin
    vt[0] = '{2'd0, 3'b100, 5'd1,  5'd2, 5'd3, 16'h0000, 1'b1, 32'h00221820};
    vt[1] = '{2'd1, 3'b100, 5'd1,  5'd5, 5'd0, 16'h0010, 1'b1, 32'h20250010};
    vt[2] = '{2'd2, 3'b000, 5'd2,  5'd4, 5'd0, 16'h0008, 1'b1, 32'h8C440008};
    vt[3] = '{2'd3, 3'b000, 5'd0,  5'd4, 5'd0, 16'h0004, 1'b1, 32'hAC040004};
    vt[4] = '{2'd1, 3'b001, 5'd1,  5'd1, 5'd0, 16'h1234, 1'b0, 32'h0};
    vt[5] = '{2'd0, 3'b111, 5'd7,  5'd8, 5'd9, 16'hFFFF, 1'b1, 32'h00E84804};
    vt[6] = '{2'd1, 3'b110, 5'd31, 5'd0, 5'd0, 16'hFFFF, 1'b1, 32'h2FE0FFFF};
    vt[7] = '{2'd2, 3'b101, 5'd3,  5'd3, 5'd0, 16'h8000, 1'b1, 32'h8C638000};

    // Reset state.
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    drive(2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    model_reset();
    #12;
    check("rst in_ready",   32'(in_ready),   32'd1);
    check("rst imem_we",    32'(imem_we),    32'd0);
    check("rst imem_addr",  32'(imem_addr),  32'd0);
    check("rst imem_wdata", imem_wdata,      32'd0);
    check("rst word_cnt",   32'(word_cnt),   32'd0);
    check("rst full",       32'(full),       32'd0);
    check("rst err",        32'(err),        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table; a clear pulse restarts whenever the memory fills.
    for (int k = 0; k < 8; k++) begin
      if (m_cnt == DEPTH) begin
        check("tbl full", 32'(full), 32'd1);
        clear = 1'b1; cycle(); clear = 1'b0;
      end
      drive(vt[k].f, vt[k].op, vt[k].s, vt[k].t, vt[k].d, vt[k].i);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      scramble();
      check("tbl we", 32'(imem_we), 32'(vt[k].legal));
      if (vt[k].legal) check("tbl word", imem_wdata, vt[k].word);
      else check("tbl err", 32'(err), 32'd1);
      cycle();
`ifdef ENC_CHECKSUM_EN
      if (k == 3)
        check("tbl checksum", checksum, 32'h00221820 ^ 32'h20250010 ^ 32'h8C440008 ^ 32'hAC040004);
`endif
    end

    // in_valid held high: exactly DEPTH writes at addresses 0..DEPTH-1, then stall.
    clear = 1'b1; cycle(); clear = 1'b0;
    drive(2'd0, 3'b101, 5'd4, 5'd5, 5'd6, 16'h0);
    in_valid = 1'b1;
    writes = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (imem_we) begin
        check("hold addr", 32'(imem_addr), 32'(writes));
        writes++;
      end
    end
    in_valid = 1'b0;
    check("hold writes",   32'(writes),   32'(DEPTH));
    check("hold full",     32'(full),     32'd1);
    check("hold word_cnt", 32'(word_cnt), 32'(DEPTH));
    clear = 1'b1; cycle(); clear = 1'b0;
    check("post-clear cnt", 32'(word_cnt), 32'd0);

    // clear during WRITE drops the pending write.
    drive(2'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0040);
    in_valid = 1'b1; cycle(); in_valid = 1'b0;
    check("cw we", 32'(imem_we), 32'd1);
    clear = 1'b1; cycle(); clear = 1'b0;
    check("cw we dropped", 32'(imem_we), 32'd0);
    check("cw cnt",        32'(word_cnt), 32'd0);
    cycle();

    // clear together with in_valid: bundle not accepted.
    drive(2'd0, 3'd4, 5'd1, 5'd1, 5'd1, 16'h0);
    clear = 1'b1; in_valid = 1'b1; cycle();
    clear = 1'b0; in_valid = 1'b0;
    check("cv no write", 32'(imem_we), 32'd0);
    cycle();

    // rst_n low mid-WRITE: outputs return to reset values at once.
    drive(2'd1, 3'b011, 5'd1, 5'd1, 5'd0, 16'h0); in_valid = 1'b1; cycle();
    drive(2'd2, 3'd0, 5'd9, 5'd10, 5'd0, 16'h0100); cycle(); in_valid = 1'b0;
    check("rw we", 32'(imem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rw imem_we",    32'(imem_we),   32'd0);
    check("rw imem_addr",  32'(imem_addr), 32'd0);
    check("rw imem_wdata", imem_wdata,     32'd0);
    check("rw word_cnt",   32'(word_cnt),  32'd0);
    check("rw full",       32'(full),      32'd0);
    check("rw err",        32'(err),       32'd0);
`ifdef ENC_CHECKSUM_EN
    check("rw checksum",   checksum,       32'd0);
`endif
    model_reset();
    rst_n = 1'b1;
    cycle();

    // Randomized traffic against the model.
    for (int r = 0; r < 500; r++) begin
      clear    = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      scramble();
      cycle();
    end
    clear = 1'b0; in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
